// File: rtl/divider_sequencer.sv
// divider_sequencer: RV32M DIV/DIVU/REM/REMU restoring divider, 1 bit per cycle.
// Define DIV_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module divider_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [4:0]      select_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REM  = 5'd18;
    localparam logic [4:0] OP_REMU = 5'd19;

    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_e;

    state_e           state_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  dvs_q;
    logic [XLEN-1:0]  orig_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             is_rem_q;
    logic             div0_q;
    logic             ovf_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    logic             op_div;
    logic             op_signed;
    logic             op_rem;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  a_mag;
    logic [XLEN-1:0]  b_mag;
    logic             div0;
    logic             ovf;
    logic             accept;
    state_e           start_state;

    logic [XLEN:0]    rem_sh;
    logic             ge;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  result_d;

    // Decode the op code into divide kind, signedness and result select.
    always_comb begin
        op_div    = 1'b0;
        op_signed = 1'b0;
        op_rem    = 1'b0;
        unique case (select_i)
            OP_DIV: begin
                op_div    = 1'b1;
                op_signed = 1'b1;
            end
            OP_DIVU: begin
                op_div    = 1'b1;
            end
            OP_REM: begin
                op_div    = 1'b1;
                op_signed = 1'b1;
                op_rem    = 1'b1;
            end
            OP_REMU: begin
                op_div    = 1'b1;
                op_rem    = 1'b1;
            end
            default: begin
                op_div    = 1'b0;
            end
        endcase
    end

    assign a_neg  = op_signed & data1_i[XLEN-1];
    assign b_neg  = op_signed & data2_i[XLEN-1];
    assign a_mag  = a_neg ? (~data1_i + ONE) : data1_i;
    assign b_mag  = b_neg ? (~data2_i + ONE) : data2_i;
    assign div0   = (data2_i == '0);
    assign ovf    = op_signed & (data1_i == INT_MIN) & (data2_i == '1);
    assign accept = start_i & op_div & ~flush_i;

`ifdef DIV_EARLY_OUT_EN
    assign start_state = (div0 | ovf) ? S_FIN : S_CALC;
`else
    assign start_state = S_CALC;
`endif

    // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        ge     = (rem_sh >= {1'b0, dvs_q});
        rem_d  = ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
        quo_d  = {quo_q[XLEN-2:0], ge};
    end

    // Sign correction and RISC-V special cases applied in FIN.
    always_comb begin
        quo_fix = neg_quo_q ? (~quo_q + ONE) : quo_q;
        rem_fix = neg_rem_q ? (~rem_q + ONE) : rem_q;
        if (div0_q) begin
            result_d = is_rem_q ? orig_q : '1;
        end else if (ovf_q) begin
            result_d = is_rem_q ? '0 : INT_MIN;
        end else begin
            result_d = is_rem_q ? rem_fix : quo_fix;
        end
    end

    // Sequencer FSM with latched operands, iteration counter and outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            orig_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        quo_q     <= a_mag;
                        dvs_q     <= b_mag;
                        orig_q    <= data1_i;
                        rem_q     <= '0;
                        cnt_q     <= CNT_W'(XLEN);
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        is_rem_q  <= op_rem;
                        div0_q    <= div0;
                        ovf_q     <= ovf;
                        state_q   <= start_state;
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    if (!flush_i) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// tb_divider_sequencer: directed and random checks of divider_sequencer.
// Expected results come from a behavioural model via a scoreboard queue.
module tb_divider_sequencer;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_DIVU = 5'd17;
    localparam logic [4:0] OP_REM  = 5'd18;
    localparam logic [4:0] OP_REMU = 5'd19;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  select_i = 5'd0;
    logic [31:0] data1_i = 32'd0;
    logic [31:0] data2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'd0;

    divider_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .select_i (select_i),
        .data1_i  (data1_i),
        .data2_i  (data2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op == OP_DIVU) begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
        end
        if (op == OP_REMU) begin
            if (b == 0) return a;
            return a % b;
        end
        if (op == OP_DIV) begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            return 32'(sa / sb);
        end
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return 32'(sa % sb);
    endfunction

    function automatic int exp_lat(input logic [4:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) &&
            a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`else
        if (op == OP_ADD) return 0;
`endif
        return 33;
    endfunction

    // Issue one op, poke START at cycle 'poke' (0 = never), check result.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        int          k;
        int          lat;
        logic [31:0] exp;
        data1_i  = a;
        data2_i  = b;
        select_i = op;
        start_i  = 1'b1;
        sb_q.push_back(model(op, a, b));
        lat = exp_lat(op, a, b);
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        data1_i = $urandom;
        data2_i = $urandom;
        chk({tag, "_busy_e0"}, 32'(busy_o), 32'd1);
        k = 0;
        while (k < 60) begin
            @(posedge clk_i);
            #1;
            k++;
            if (done_o) break;
            start_i = (k == poke);
            if (k == poke) select_i = OP_DIVU;
            chk({tag, "_busy_run"}, 32'(busy_o), 32'd1);
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, 32'(k), 32'(lat));
        chk({tag, "_busy_done"}, 32'(busy_o), 32'd0);
        exp = sb_q.pop_front();
        chk({tag, "_result"}, result_o, exp);
        last_result = exp;
    endtask

    task automatic no_done_window(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            seen = seen | done_o;
        end
        chk({tag, "_no_done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [4:0] ops[4];
        ops[0] = OP_DIV;
        ops[1] = OP_DIVU;
        ops[2] = OP_REM;
        ops[3] = OP_REMU;

        #1 rst_ni = 1'b0;
        #12;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 0);
        run_op("rem_100_7_b2b", OP_REM, 32'd100, 32'd7, 0);
        @(posedge clk_i);
        #1;
        chk("done_strobe_fall", 32'(done_o), 32'd0);

        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_big_2", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 0);
        run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 0);
        run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 0);
        run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 0);

        for (int i = 0; i < 6; i++) begin
            run_op("rand", ops[$urandom_range(0, 3)], $urandom,
                   $urandom >> $urandom_range(0, 31), 0);
        end

        run_op("start_busy", OP_DIV, 32'd1000, 32'd9, 10);
        no_done_window("start_busy", 40);

        select_i = OP_ADD;
        data1_i  = 32'd3;
        data2_i  = 32'd4;
        start_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk("add_busy", 32'(busy_o), 32'd0);
            chk("add_done", 32'(done_o), 32'd0);
        end
        start_i = 1'b0;

        select_i = OP_DIV;
        data1_i  = 32'd77;
        data2_i  = 32'd5;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        no_done_window("flush", 40);
        chk("flush_result", result_o, last_result);

        start_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        chk("flush_start_busy", 32'(busy_o), 32'd0);
        no_done_window("flush_start", 36);

        select_i = OP_DIVU;
        data1_i  = 32'd500;
        data2_i  = 32'd3;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        no_done_window("midrst", 36);

        run_op("post_reset", OP_REMU, 32'd1234567, 32'd1000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
